// File: rtl/mbus_pwr_pkg.sv
// Shared definitions for the MBus layer power sequencers: state encoding,
// the {sleep, clkenb, reset, iso} pattern for each state, and small helpers.
package mbus_pwr_pkg;

    typedef enum logic [2:0] {
        PWR_OFF    = 3'd0,
        PWR_UP_PWR = 3'd1,
        PWR_UP_CLK = 3'd2,
        PWR_UP_RST = 3'd3,
        PWR_ACTIVE = 3'd4,
        PWR_DN_ISO = 3'd5,
        PWR_DN_RST = 3'd6,
        PWR_DN_CLK = 3'd7
    } pwr_state_e;

    localparam logic [3:0] PAT_OFF    = 4'b1111;
    localparam logic [3:0] PAT_UP_PWR = 4'b0111;
    localparam logic [3:0] PAT_UP_CLK = 4'b0011;
    localparam logic [3:0] PAT_UP_RST = 4'b0001;
    localparam logic [3:0] PAT_ACTIVE = 4'b0000;
    localparam logic [3:0] PAT_DN_ISO = 4'b0001;
    localparam logic [3:0] PAT_DN_RST = 4'b0011;
    localparam logic [3:0] PAT_DN_CLK = 4'b0111;

    function automatic logic [3:0] state_pattern(pwr_state_e s);
        logic [3:0] pat;
        case (s)
            PWR_OFF:    pat = PAT_OFF;
            PWR_UP_PWR: pat = PAT_UP_PWR;
            PWR_UP_CLK: pat = PAT_UP_CLK;
            PWR_UP_RST: pat = PAT_UP_RST;
            PWR_ACTIVE: pat = PAT_ACTIVE;
            PWR_DN_ISO: pat = PAT_DN_ISO;
            PWR_DN_RST: pat = PAT_DN_RST;
            PWR_DN_CLK: pat = PAT_DN_CLK;
            default:    pat = PAT_OFF;
        endcase
        return pat;
    endfunction

    function automatic logic is_transitional(pwr_state_e s);
        return (s != PWR_OFF) && (s != PWR_ACTIVE);
    endfunction

    function automatic logic is_power_up(pwr_state_e s);
        return (s == PWR_UP_PWR) || (s == PWR_UP_CLK) || (s == PWR_UP_RST);
    endfunction

    // Successor of each timed step; steady states map to themselves.
    function automatic pwr_state_e step_next(pwr_state_e s);
        pwr_state_e nxt;
        case (s)
            PWR_UP_PWR: nxt = PWR_UP_CLK;
            PWR_UP_CLK: nxt = PWR_UP_RST;
            PWR_UP_RST: nxt = PWR_ACTIVE;
            PWR_DN_ISO: nxt = PWR_DN_RST;
            PWR_DN_RST: nxt = PWR_DN_CLK;
            PWR_DN_CLK: nxt = PWR_OFF;
            default:    nxt = s;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mbus_layer_pwr_fsm.sv
// One layer's power sequencer: power -> clock -> reset -> isolation on wake,
// the reverse on sleep, with pending requests held until the sequence lands.
module mbus_layer_pwr_fsm
    import mbus_pwr_pkg::*;
#(
    parameter int DLY_WIDTH = 4,
    parameter int STEP_DLY  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wake,
    input  logic sleep_req,
    output logic lrc_sleep,
    output logic lrc_clkenb,
    output logic lrc_reset,
    output logic lrc_isolate,
    output logic layer_active,
    output logic busy
);

    localparam logic [DLY_WIDTH-1:0] LAST_CNT = DLY_WIDTH'(STEP_DLY - 1);

    pwr_state_e           state_q, state_d;
    logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_wake_q, pend_wake_d;
    logic                 pend_sleep_q, pend_sleep_d;
    logic [3:0]           pat_q, pat_d;
    logic                 active_q, active_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        pend_wake_d  = pend_wake_q;
        pend_sleep_d = pend_sleep_q;

        case (state_q)
            PWR_OFF: begin
                if (wake || pend_wake_q) begin
                    state_d     = PWR_UP_PWR;
                    pend_wake_d = 1'b0;
                end
            end
            PWR_ACTIVE: begin
                if (wake) begin
                    pend_sleep_d = 1'b0;
                end else if (sleep_req || pend_sleep_q) begin
                    state_d      = PWR_DN_ISO;
                    pend_sleep_d = 1'b0;
                end
            end
            default: begin
                // A running sequence is never reversed; the opposite request waits.
                if (is_power_up(state_q)) begin
                    if (sleep_req) pend_sleep_d = 1'b1;
                end else begin
                    if (wake) pend_wake_d = 1'b1;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = step_next(state_q);
                end else begin
                    cnt_d = cnt_q + DLY_WIDTH'(1);
                end
            end
        endcase

        pat_d    = state_pattern(state_q);
        active_d = (state_q == PWR_ACTIVE);
        busy_d   = is_transitional(state_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= PWR_OFF;
            cnt_q        <= '0;
            pend_wake_q  <= 1'b0;
            pend_sleep_q <= 1'b0;
            pat_q        <= PAT_OFF;
            active_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_wake_q  <= pend_wake_d;
            pend_sleep_q <= pend_sleep_d;
            pat_q        <= pat_d;
            active_q     <= active_d;
            busy_q       <= busy_d;
        end
    end

    assign lrc_sleep    = pat_q[3];
    assign lrc_clkenb   = pat_q[2];
    assign lrc_reset    = pat_q[1];
    assign lrc_isolate  = pat_q[0];
    assign layer_active = active_q;
    assign busy         = busy_q;

endmodule

// File: rtl/mbus_multi_layer_sleep_ctrl.sv
// Always-on power sequencer for several MBus layers, plus the masked interrupt
// wakeup OR that can bring up a selectable set of layers.
module mbus_multi_layer_sleep_ctrl #(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_WAKEUP = 3,
    parameter int DLY_WIDTH  = 4,
    parameter int STEP_DLY   = 2
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [NUM_LAYERS-1:0] WAKE_REQ,
    input  logic [NUM_LAYERS-1:0] SLEEP_REQ,
    input  logic [NUM_WAKEUP-1:0] INT_REQ,
    input  logic [NUM_WAKEUP-1:0] INT_MASK,
    input  logic [NUM_LAYERS-1:0] INT_LAYER_EN,
    output logic [NUM_LAYERS-1:0] LRC_SLEEP,
    output logic [NUM_LAYERS-1:0] LRC_CLKENB,
    output logic [NUM_LAYERS-1:0] LRC_RESET,
    output logic [NUM_LAYERS-1:0] LRC_ISOLATE,
    output logic [NUM_LAYERS-1:0] LAYER_ACTIVE,
    output logic                  WAKEUP_REQ_ORED,
    output logic                  SEQ_BUSY
);

    logic                  wakeup_ored_q, wakeup_ored_d;
    logic [NUM_LAYERS-1:0] layer_wake;
    logic [NUM_LAYERS-1:0] layer_busy;

    // The interrupt wake uses the registered OR, so layers follow one cycle later.
    always_comb begin
        wakeup_ored_d = |(INT_REQ & INT_MASK);
        layer_wake    = WAKE_REQ | ({NUM_LAYERS{wakeup_ored_q}} & INT_LAYER_EN);
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wakeup_ored_q <= 1'b0;
        end else begin
            wakeup_ored_q <= wakeup_ored_d;
        end
    end

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        mbus_layer_pwr_fsm #(
            .DLY_WIDTH (DLY_WIDTH),
            .STEP_DLY  (STEP_DLY)
        ) u_layer (
            .clk          (CLK),
            .rst_n        (RESETn),
            .wake         (layer_wake[i]),
            .sleep_req    (SLEEP_REQ[i]),
            .lrc_sleep    (LRC_SLEEP[i]),
            .lrc_clkenb   (LRC_CLKENB[i]),
            .lrc_reset    (LRC_RESET[i]),
            .lrc_isolate  (LRC_ISOLATE[i]),
            .layer_active (LAYER_ACTIVE[i]),
            .busy         (layer_busy[i])
        );
    end

    assign WAKEUP_REQ_ORED = wakeup_ored_q;
    assign SEQ_BUSY        = |layer_busy;

endmodule

// File: tb/tb_mbus_multi_layer_sleep_ctrl.sv
// Bench for mbus_multi_layer_sleep_ctrl: directed timing scenarios plus random
// traffic checked against a rail-level timing model of each layer.
module tb_mbus_multi_layer_sleep_ctrl;

    localparam int NL = 4;
    localparam int NW = 3;
    localparam int DW = 4;
    localparam int SD = 2;

    localparam int M_OFF = 0;
    localparam int M_UP  = 1;
    localparam int M_ON  = 2;
    localparam int M_DN  = 3;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic [NL-1:0] WAKE_REQ, SLEEP_REQ, INT_LAYER_EN;
    logic [NW-1:0] INT_REQ, INT_MASK;
    logic [NL-1:0] LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE;
    logic          WAKEUP_REQ_ORED, SEQ_BUSY;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each layer is off, rising, on or falling, with t = edges since start.
    int            m_mode [NL];
    int            m_t    [NL];
    bit            m_pw   [NL];
    bit            m_ps   [NL];
    logic          m_ored;
    logic [NL-1:0] e_sleep, e_clk, e_rst, e_iso, e_act;
    logic          e_busy;

    mbus_multi_layer_sleep_ctrl #(
        .NUM_LAYERS (NL),
        .NUM_WAKEUP (NW),
        .DLY_WIDTH  (DW),
        .STEP_DLY   (SD)
    ) dut (
        .CLK             (CLK),
        .RESETn          (RESETn),
        .WAKE_REQ        (WAKE_REQ),
        .SLEEP_REQ       (SLEEP_REQ),
        .INT_REQ         (INT_REQ),
        .INT_MASK        (INT_MASK),
        .INT_LAYER_EN    (INT_LAYER_EN),
        .LRC_SLEEP       (LRC_SLEEP),
        .LRC_CLKENB      (LRC_CLKENB),
        .LRC_RESET       (LRC_RESET),
        .LRC_ISOLATE     (LRC_ISOLATE),
        .LAYER_ACTIVE    (LAYER_ACTIVE),
        .WAKEUP_REQ_ORED (WAKEUP_REQ_ORED),
        .SEQ_BUSY        (SEQ_BUSY)
    );

    always #5 CLK = ~CLK;

    // Number of rails released: 1 power, 2 clock, 3 reset, 4 isolation.
    function automatic int rails_up(int mode, int t);
        case (mode)
            M_UP:    return 1 + t / SD;
            M_ON:    return 4;
            M_DN:    return 3 - t / SD;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int   lvl;
        logic w;
        if (!RESETn) begin
            for (int i = 0; i < NL; i++) begin
                m_mode[i] = M_OFF; m_t[i] = 0; m_pw[i] = 0; m_ps[i] = 0;
            end
            e_sleep = '1; e_clk = '1; e_rst = '1; e_iso = '1; e_act = '0;
            e_busy = 1'b0; m_ored = 1'b0;
            return;
        end
        e_busy = 1'b0;
        for (int i = 0; i < NL; i++) begin
            lvl        = rails_up(m_mode[i], m_t[i]);
            e_sleep[i] = (lvl < 1);
            e_clk[i]   = (lvl < 2);
            e_rst[i]   = (lvl < 3);
            e_iso[i]   = (lvl < 4);
            e_act[i]   = (m_mode[i] == M_ON);
            if (m_mode[i] == M_UP || m_mode[i] == M_DN) e_busy = 1'b1;
            w = WAKE_REQ[i] | (m_ored & INT_LAYER_EN[i]);
            case (m_mode[i])
                M_OFF: if (w || m_pw[i]) begin
                    m_mode[i] = M_UP; m_t[i] = 0; m_pw[i] = 0;
                end
                M_UP: begin
                    if (SLEEP_REQ[i]) m_ps[i] = 1;
                    m_t[i]++;
                    if (m_t[i] == 3 * SD) m_mode[i] = M_ON;
                end
                M_ON: begin
                    if (w) m_ps[i] = 0;
                    else if (SLEEP_REQ[i] || m_ps[i]) begin
                        m_mode[i] = M_DN; m_t[i] = 0; m_ps[i] = 0;
                    end
                end
                default: begin
                    if (w) m_pw[i] = 1;
                    m_t[i]++;
                    if (m_t[i] == 3 * SD) m_mode[i] = M_OFF;
                end
            endcase
        end
        m_ored = |(INT_REQ & INT_MASK);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (2) tick();
        RESETn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if ({LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, WAKEUP_REQ_ORED, SEQ_BUSY}
                !== {16'hFFFF, 4'h0, 1'b0, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL reset_idle cyc=%0d: got %b %b %b %b act=%b ored=%b busy=%b, want 1111 x4 act=0000 ored=0 busy=0",
                         k, LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, WAKEUP_REQ_ORED, SEQ_BUSY);
            end
        end
    endtask

    task automatic test_power_up();
        logic [4:0] got, exp;
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) WAKE_REQ = 4'b0001;
            tick();
            WAKE_REQ = '0;
            got = {LRC_SLEEP[0], LRC_CLKENB[0], LRC_RESET[0], LRC_ISOLATE[0], LAYER_ACTIVE[0]};
            exp = {k < 1, k < 3, k < 5, k < 7, k >= 7};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL pwr_up_l0 edge=%0d: got %b want %b", k, got, exp);
            end
            n_cmp++;
            if ({LRC_SLEEP[3:1], LRC_CLKENB[3:1], LRC_RESET[3:1], LRC_ISOLATE[3:1], LAYER_ACTIVE[3:1]} !== 15'h7FF8) begin
                n_err++;
                $display("[TB] FAIL pwr_up_others edge=%0d: got %b %b %b %b %b want all 1111 inactive",
                         k, LRC_SLEEP[3:1], LRC_CLKENB[3:1], LRC_RESET[3:1], LRC_ISOLATE[3:1], LAYER_ACTIVE[3:1]);
            end
            n_cmp++;
            if (SEQ_BUSY !== (k >= 1 && k <= 6)) begin
                n_err++;
                $display("[TB] FAIL pwr_up_busy edge=%0d: got %b want %b", k, SEQ_BUSY, (k >= 1 && k <= 6));
            end
        end
    endtask

    task automatic test_power_down();
        logic [4:0] got, exp;
        WAKE_REQ = 4'b0010;
        tick();
        WAKE_REQ = '0;
        repeat (8) tick();
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) SLEEP_REQ = 4'b0010;
            tick();
            SLEEP_REQ = '0;
            got = {LRC_SLEEP[1], LRC_CLKENB[1], LRC_RESET[1], LRC_ISOLATE[1], LAYER_ACTIVE[1]};
            exp = {k >= 7, k >= 5, k >= 3, k >= 1, k == 0};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL pwr_dn_l1 edge=%0d: got %b want %b", k, got, exp);
            end
            n_cmp++;
            if ({SEQ_BUSY, LAYER_ACTIVE[0]} !== {(k >= 1 && k <= 6), 1'b1}) begin
                n_err++;
                $display("[TB] FAIL pwr_dn_busy edge=%0d: got busy=%b act0=%b want busy=%b act0=1",
                         k, SEQ_BUSY, LAYER_ACTIVE[0], (k >= 1 && k <= 6));
            end
        end
    endtask

    task automatic test_pending_sleep();
        logic [5:0] got, exp;
        for (int k = 0; k <= 15; k++) begin
            if (k == 0) WAKE_REQ  = 4'b0100;
            if (k == 2) SLEEP_REQ = 4'b0100;
            tick();
            WAKE_REQ  = '0;
            SLEEP_REQ = '0;
            got = {LRC_SLEEP[2], LRC_CLKENB[2], LRC_RESET[2], LRC_ISOLATE[2], LAYER_ACTIVE[2], SEQ_BUSY};
            exp = {!(k >= 1 && k <= 13), !(k >= 3 && k <= 11), !(k >= 5 && k <= 9), k != 7, k == 7,
                   (k >= 1 && k <= 6) || (k >= 8 && k <= 13)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL pend_sleep_l2 edge=%0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_interrupt();
        INT_MASK     = 3'b010;
        INT_LAYER_EN = 4'b1000;
        INT_REQ      = 3'b001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({WAKEUP_REQ_ORED, LRC_SLEEP[3]} !== 2'b01) begin
                n_err++;
                $display("[TB] FAIL int_masked cyc=%0d: got ored=%b sleep3=%b want ored=0 sleep3=1",
                         k, WAKEUP_REQ_ORED, LRC_SLEEP[3]);
            end
        end
        for (int k = 0; k <= 3; k++) begin
            INT_REQ = (k == 0) ? 3'b010 : 3'b000;
            tick();
            n_cmp++;
            if ({WAKEUP_REQ_ORED, LRC_SLEEP[3]} !== {k == 0, k < 2}) begin
                n_err++;
                $display("[TB] FAIL int_wake edge=%0d: got ored=%b sleep3=%b want ored=%b sleep3=%b",
                         k, WAKEUP_REQ_ORED, LRC_SLEEP[3], k == 0, k < 2);
            end
        end
        repeat (6) tick();
        INT_MASK     = '0;
        INT_LAYER_EN = '0;
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k <= 4; k++) begin
            if (k == 0) begin WAKE_REQ = 4'b0010; SLEEP_REQ = 4'b0001; end
            if (k == 2) begin WAKE_REQ = 4'b0001; SLEEP_REQ = 4'b0010; end
            if (k == 4) RESETn = 1'b0;
            tick();
            WAKE_REQ  = '0;
            SLEEP_REQ = '0;
        end
        RESETn = 1'b1;
        n_cmp++;
        if ({LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, SEQ_BUSY} !== {16'hFFFF, 4'h0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_abort: got %b %b %b %b act=%b busy=%b want 1111 x4 act=0000 busy=0",
                     LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, SEQ_BUSY);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if ({LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, SEQ_BUSY} !== {16'hFFFF, 4'h0, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL reset_no_pending cyc=%0d: got %b %b %b %b act=%b busy=%b want all off",
                         k, LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, SEQ_BUSY);
            end
        end
    endtask

    task automatic test_random();
        logic [21:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            RESETn = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < NL; i++) begin
                WAKE_REQ[i]  = ($urandom_range(0, 9) == 0);
                SLEEP_REQ[i] = ($urandom_range(0, 6) == 0);
            end
            for (int j = 0; j < NW; j++) INT_REQ[j] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) begin
                INT_MASK     = NW'($urandom);
                INT_LAYER_EN = NL'($urandom);
            end
            tick();
            got = {LRC_SLEEP, LRC_CLKENB, LRC_RESET, LRC_ISOLATE, LAYER_ACTIVE, WAKEUP_REQ_ORED, SEQ_BUSY};
            exp = {e_sleep, e_clk, e_rst, e_iso, e_act, m_ored, e_busy};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL random cyc=%0d: got %b want %b", c, got, exp);
            end
        end
        RESETn    = 1'b1;
        WAKE_REQ  = '0;
        SLEEP_REQ = '0;
        INT_REQ   = '0;
    endtask

    initial begin
        RESETn       = 1'b0;
        WAKE_REQ     = '0;
        SLEEP_REQ    = '0;
        INT_REQ      = '0;
        INT_MASK     = '0;
        INT_LAYER_EN = '0;
        $display("[TB] starting mbus_multi_layer_sleep_ctrl bench");
        test_reset();
        test_power_up();
        test_power_down();
        test_pending_sleep();
        test_interrupt();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
